// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing controller: opcode and FSM state
// encodings, datapath widths and the legal-opcode helper.
package alu_pkg;

  localparam int ALU_DATA_W = 8;
  localparam int ALU_OP_W   = 4;
  localparam int ALU_OP_MAX = 5;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    AND = 4'd2,
    OR  = 4'd3,
    SLT = 4'd4,
    XOR = 4'd5
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } ctrl_state_e;

  // Opcodes above the last defined ALU operation are reported as errors
  function automatic logic op_is_illegal(input int unsigned op);
    return (op > ALU_OP_MAX);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after ptr, wrapping modulo NUM_REQ. Pointer state is owned by the caller.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);

  // Rotating priority scan starting at ptr
  always_comb begin
    int  cand;
    logic found;
    gnt   = {NUM_REQ{1'b0}};
    idx   = {ID_W{1'b0}};
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end else begin
        cand = cand;
      end
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand[ID_W-1:0];
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one combinational ALU between NUM_REQ requesters: round-robin
// grant, operand latching, result capture and a tagged valid/ready response.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = ALU_DATA_W,
  parameter int OP_W    = ALU_OP_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [OP_W-1:0]           alu_op,
  input  logic [DATA_W-1:0]         alu_out,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      rsp_err
);

  ctrl_state_e         state_r;
  ctrl_state_e         state_nxt_s;
  logic [ID_W-1:0]     rr_ptr_r;
  logic [ID_W-1:0]     rr_ptr_nxt_s;
  logic [ID_W-1:0]     id_r;
  logic [NUM_REQ-1:0]  gnt_s;
  logic [ID_W-1:0]     gnt_idx_s;
  logic                gnt_any_s;
  logic                arb_en_s;
  logic [DATA_W-1:0]   alu_a_r;
  logic [DATA_W-1:0]   alu_b_r;
  logic [OP_W-1:0]     alu_op_r;
  logic                rsp_valid_r;
  logic [DATA_W-1:0]   rsp_data_r;
  logic [ID_W-1:0]     rsp_id_r;
  logic                rsp_err_r;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_r),
    .en  (arb_en_s),
    .gnt (gnt_s),
    .idx (gnt_idx_s)
  );

  assign gnt_any_s = |gnt_s;

  // Pointer moves to the slot just after the winner, wrapping at NUM_REQ
  always_comb begin
    if (gnt_idx_s == ID_W'(NUM_REQ - 1)) begin
      rr_ptr_nxt_s = {ID_W{1'b0}};
    end else begin
      rr_ptr_nxt_s = gnt_idx_s + {{(ID_W-1){1'b0}}, 1'b1};
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (gnt_any_s) begin
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC: state_nxt_s = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: arbitration only runs in IDLE, and never while reset is held
  always_comb begin
    if ((state_r == IDLE) && rst_n) begin
      arb_en_s = 1'b1;
    end else begin
      arb_en_s = 1'b0;
    end
    req_ready = gnt_s;
  end

  // Datapath: grant latching, pointer update, result capture and response hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r    <= {ID_W{1'b0}};
      id_r        <= {ID_W{1'b0}};
      alu_a_r     <= {DATA_W{1'b0}};
      alu_b_r     <= {DATA_W{1'b0}};
      alu_op_r    <= {OP_W{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {DATA_W{1'b0}};
      rsp_id_r    <= {ID_W{1'b0}};
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (gnt_any_s) begin
            alu_a_r  <= req_a[gnt_idx_s*DATA_W +: DATA_W];
            alu_b_r  <= req_b[gnt_idx_s*DATA_W +: DATA_W];
            alu_op_r <= req_op[gnt_idx_s*OP_W +: OP_W];
            id_r     <= gnt_idx_s;
            rr_ptr_r <= rr_ptr_nxt_s;
          end
        end
        EXEC: begin
          // Illegal opcodes return zero whatever the ALU produced
          if (op_is_illegal(32'(alu_op_r))) begin
            rsp_data_r <= {DATA_W{1'b0}};
            rsp_err_r  <= 1'b1;
          end else begin
            rsp_data_r <= alu_out;
            rsp_err_r  <= 1'b0;
          end
          rsp_id_r    <= id_r;
          rsp_valid_r <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign alu_a     = alu_a_r;
  assign alu_b     = alu_b_r;
  assign alu_op    = alu_op_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed scenarios plus randomized traffic checked
// against a transaction-level model of arbitration and ALU arithmetic.
module tb_alu_share_ctrl;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int OW = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic [N*OW-1:0] req_op;
  logic [DW-1:0]   alu_a;
  logic [DW-1:0]   alu_b;
  logic [OW-1:0]   alu_op;
  logic [DW-1:0]   alu_out;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_data;
  logic [IW-1:0]   rsp_id;
  logic            rsp_err;

  int n_chk  = 0;
  int n_pass = 0;

  alu_share_ctrl #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared ALU; undefined opcodes drive junk
  always_comb begin
    case (alu_op)
      4'd0:    alu_out = alu_a + alu_b;
      4'd1:    alu_out = alu_a - alu_b;
      4'd2:    alu_out = alu_a & alu_b;
      4'd3:    alu_out = alu_a | alu_b;
      4'd4:    alu_out = (alu_a < alu_b) ? 8'd1 : 8'd0;
      4'd5:    alu_out = alu_a ^ alu_b;
      default: alu_out = 8'hEE;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] ref_res(input int a, input int b, input int op);
    case (op)
      0:       return 8'((a + b) % 256);
      1:       return 8'((a - b + 256) % 256);
      2:       return 8'(a & b);
      3:       return 8'(a | b);
      4:       return (a < b) ? 8'd1 : 8'd0;
      5:       return 8'(a ^ b);
      default: return 8'd0;
    endcase
  endfunction

  task automatic set_req(input int r, input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op);
    req_valid[r]         = v;
    req_a[r*DW +: DW]    = a;
    req_b[r*DW +: DW]    = b;
    req_op[r*OW +: OW]   = op;
  endtask

  task automatic single(input int r, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] op, input string tag);
    logic [7:0] ed;
    ed = ref_res(int'(a), int'(b), int'(op));
    @(negedge clk);
    set_req(r, 1'b1, a, b, op);
    rsp_ready = 1'b0;
    #1 chk({tag, ".rdy"}, req_ready, 32'(1 << r));
    @(negedge clk);
    req_valid[r] = 1'b0;
    chk({tag, ".lat1"}, rsp_valid, 0);
    @(negedge clk);
    chk({tag, ".vld"}, rsp_valid, 1);
    chk({tag, ".data"}, rsp_data, ed);
    chk({tag, ".id"}, rsp_id, r);
    chk({tag, ".err"}, rsp_err, (op > 4'd5) ? 1 : 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, ".done"}, rsp_valid, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Random-phase model state
  int         mph;
  int         m_ptr;
  int         e_g;
  int         g;
  int         drop;
  logic [7:0] e_a, e_b;
  logic [3:0] e_op;
  int         waitc [N];

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.rdy", req_ready, 0);
    chk("rst.vld", rsp_valid, 0);
    rst_n = 1'b1;

    // Reset while a response is pending, after req 1 moved the pointer to 2
    @(negedge clk);
    set_req(1, 1'b1, 8'd3, 8'd4, 4'd0);
    #1 chk("t1.pre_rdy", req_ready, 32'b0010);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("t1.pre_vld", rsp_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1.rst_vld", rsp_valid, 0);
    chk("t1.rst_data", rsp_data, 0);
    chk("t1.rst_alu", {alu_a, alu_b, alu_op}, 0);
    chk("t1.rst_id_err", {rsp_id, rsp_err}, 0);
    chk("t1.rst_rdy", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    set_req(1, 1'b1, 8'd3, 8'd4, 4'd0);
    set_req(3, 1'b1, 8'd1, 8'd1, 4'd1);
    #1 chk("t1.ptr0", req_ready, 32'b0010);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("t1.data", rsp_data, 7);
    chk("t1.id", rsp_id, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // All four requesters valid from reset: grant order 0,1,2,3,0
    do_reset();
    set_req(0, 1'b1, 8'd5, 8'd6, 4'd1);
    set_req(1, 1'b1, 8'hF0, 8'h3C, 4'd2);
    set_req(2, 1'b1, 8'hF0, 8'h0F, 4'd3);
    set_req(3, 1'b1, 8'd2, 8'd9, 4'd4);
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 chk("t3.rdy", req_ready, 32'(1 << (k % 4)));
      @(negedge clk);
      @(negedge clk);
      chk("t3.data", rsp_data, (k % 4 == 0) ? 8'hFF : (k % 4 == 1) ? 8'h30 :
                               (k % 4 == 2) ? 8'hFF : 8'h01);
      chk("t3.id", rsp_id, k % 4);
      @(negedge clk);
    end
    req_valid = '0;
    rsp_ready = 1'b0;

    // Add wrap-around
    single(0, 8'd200, 8'd100, 4'd0, "t2");

    // Backpressure with req 2 waiting
    @(negedge clk);
    set_req(0, 1'b1, 8'd10, 8'd20, 4'd0);
    #1 chk("t4.rdy0", req_ready, 32'b0001);
    @(negedge clk);
    req_valid[0] = 1'b0;
    set_req(2, 1'b1, 8'd7, 8'd8, 4'd0);
    for (int h = 0; h < 6; h++) begin
      @(negedge clk);
      chk("t4.hold_vld", rsp_valid, 1);
      chk("t4.hold_data", {rsp_data, rsp_id, rsp_err}, {8'd30, 2'd0, 1'b0});
      chk("t4.hold_rdy", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1 chk("t4.rdy2", req_ready, 32'b0100);
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(negedge clk);
    chk("t4.data2", {rsp_data, rsp_id}, {8'd15, 2'd2});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Illegal opcode then a legal xor from the same requester
    single(3, 8'h12, 8'h34, 4'd9, "t5.ill");
    single(3, 8'hAA, 8'hFF, 4'd5, "t5.xor");

    // Randomized traffic against the transaction model
    do_reset();
    mph = 0;
    m_ptr = 0;
    drop = -1;
    for (int i = 0; i < N; i++) waitc[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (i == drop) begin
          req_valid[i] = 1'b0;
        end else if (req_valid[i]) begin
          if ($urandom_range(9) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          set_req(i, 1'b1, 8'($urandom), 8'($urandom), 4'($urandom_range(7)));
        end
      end
      drop = -1;
      rsp_ready = 1'($urandom_range(1));
      #1;
      case (mph)
        0: begin
          g = -1;
          for (int k = 0; k < N; k++) begin
            if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
          end
          chk("rnd.rdy", req_ready, (g < 0) ? 0 : 32'(1 << g));
          if (g >= 0) begin
            chk("rnd.fair", (waitc[g] <= N - 1) ? 1 : 0, 1);
            e_g  = g;
            e_a  = req_a[g*DW +: DW];
            e_b  = req_b[g*DW +: DW];
            e_op = req_op[g*OW +: OW];
            m_ptr = (g + 1) % N;
            drop = g;
            mph = 1;
            for (int i = 0; i < N; i++) if (i != g && req_valid[i]) waitc[i]++;
            waitc[g] = 0;
          end
        end
        1: begin
          chk("rnd.exec_rdy", req_ready, 0);
          chk("rnd.exec_vld", rsp_valid, 0);
          mph = 2;
        end
        default: begin
          chk("rnd.resp_rdy", req_ready, 0);
          chk("rnd.vld", rsp_valid, 1);
          chk("rnd.data", rsp_data, ref_res(int'(e_a), int'(e_b), int'(e_op)));
          chk("rnd.id", rsp_id, e_g);
          chk("rnd.err", rsp_err, (e_op > 4'd5) ? 1 : 0);
          chk("rnd.alu", {alu_a, alu_b, alu_op}, {e_a, e_b, e_op});
          if (rsp_ready) mph = 0;
        end
      endcase
      for (int i = 0; i < N; i++) if (!req_valid[i]) waitc[i] = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
